// File: rtl/arith_wb_buf_pkg.sv
// Types for the mul/div writeback buffer: one stored entry and the control register set.
package arith_wb_buf_pkg;
  import river_cfg_pkg::*;

  // Structs are sized for the largest supported configuration; the module uses the low bits.
  localparam int TAG_W_MAX = 8;
  localparam int PTR_W_MAX = 8;
  localparam int CNT_W_MAX = PTR_W_MAX + 1;

  typedef struct packed {
    logic [5:0]            waddr;
    logic [TAG_W_MAX-1:0]  tag;
    logic [RISCV_ARCH-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic [PTR_W_MAX-1:0] wptr;
    logic [PTR_W_MAX-1:0] rptr;
    logic [CNT_W_MAX-1:0] count;
    logic                 overflow;
  } wb_regs_t;
endpackage

// File: rtl/river_cfg_pkg.sv
// Core-wide configuration shared by the River pipeline blocks.
package river_cfg_pkg;
  localparam int RISCV_ARCH = 64;
endpackage

// File: rtl/arith_wb_buf.sv
// Circular buffer merging multiplier and divider results onto one register-file write port.
module arith_wb_buf
  import river_cfg_pkg::*;
  import arith_wb_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_mul_valid,
  input  logic [RISCV_ARCH-1:0]      i_mul_res,
  input  logic [5:0]                 i_mul_waddr,
  input  logic [TAG_W-1:0]           i_mul_tag,
  input  logic                       i_div_valid,
  input  logic [RISCV_ARCH-1:0]      i_div_res,
  input  logic [5:0]                 i_div_waddr,
  input  logic [TAG_W-1:0]           i_div_tag,
  input  logic                       i_flush,
  input  logic                       i_wready,
  output logic                       o_wena,
  output logic [5:0]                 o_waddr,
  output logic [RISCV_ARCH-1:0]      o_wdata,
  output logic [TAG_W-1:0]           o_wtag,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W_MAX-1:0] DEPTH_C  = CNT_W_MAX'(DEPTH);
  localparam logic [PTR_W_MAX-1:0] PTR_MASK = PTR_W_MAX'(DEPTH - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PTR_W > PTR_W_MAX || TAG_W > TAG_W_MAX)
  begin : g_bad_cfg
    $error("arith_wb_buf: DEPTH must be a power of two >= 2 and widths within package limits");
  end

  // Handshake: producers push with a one-cycle valid and no ready (a push that finds no
  // room is dropped and flagged); the head is popped when o_wena && i_wready at a clock edge.
  wb_entry_t mem [DEPTH];
  wb_regs_t  r;
  wb_regs_t  rin;

  logic                 pop;
  logic                 mul_we;
  logic                 div_we;
  logic [CNT_W_MAX-1:0] free;
  logic [PTR_W-1:0]     div_pos;
  wb_entry_t            mul_ent;
  wb_entry_t            div_ent;

  always_comb begin
    rin     = r;
    pop     = (r.count != '0) && i_wready;
    free    = DEPTH_C - r.count + CNT_W_MAX'(pop);
    mul_we  = i_mul_valid && (free != '0);
    // The div push sees the slot the mul push may have just taken.
    div_we  = i_div_valid && (free > CNT_W_MAX'(mul_we));
    div_pos = r.wptr[PTR_W-1:0] + PTR_W'(mul_we);
    mul_ent = '{waddr: i_mul_waddr, tag: TAG_W_MAX'(i_mul_tag), data: i_mul_res};
    div_ent = '{waddr: i_div_waddr, tag: TAG_W_MAX'(i_div_tag), data: i_div_res};

    if (i_flush) begin
      rin.wptr  = '0;
      rin.rptr  = '0;
      rin.count = '0;
      mul_we    = 1'b0;
      div_we    = 1'b0;
    end else begin
      rin.wptr  = (r.wptr + PTR_W_MAX'(mul_we) + PTR_W_MAX'(div_we)) & PTR_MASK;
      rin.rptr  = (r.rptr + PTR_W_MAX'(pop)) & PTR_MASK;
      rin.count = r.count + CNT_W_MAX'(mul_we) + CNT_W_MAX'(div_we) - CNT_W_MAX'(pop);
      if ((i_mul_valid && !mul_we) || (i_div_valid && !div_we)) begin
        rin.overflow = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; only the control registers are.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r <= '0;
    end else begin
      r <= rin;
    end
    if (mul_we) begin
      mem[r.wptr[PTR_W-1:0]] <= mul_ent;
    end
    if (div_we) begin
      mem[div_pos] <= div_ent;
    end
  end

  assign o_wena     = (r.count != '0);
  assign o_waddr    = mem[r.rptr[PTR_W-1:0]].waddr;
  assign o_wdata    = mem[r.rptr[PTR_W-1:0]].data;
  assign o_wtag     = mem[r.rptr[PTR_W-1:0]].tag[TAG_W-1:0];
  assign o_full     = (r.count >= DEPTH_C - CNT_W_MAX'(1));
  assign o_count    = r.count[CNT_W-1:0];
  assign o_overflow = r.overflow;

endmodule

// File: tb/tb_arith_wb_buf.sv
// Directed bench for arith_wb_buf at DEPTH=4, TAG_W=4 with hand-computed expectations.
module tb_arith_wb_buf;
  import river_cfg_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_mul_valid;
  logic [RISCV_ARCH-1:0] i_mul_res;
  logic [5:0]            i_mul_waddr;
  logic [TAG_W-1:0]      i_mul_tag;
  logic                  i_div_valid;
  logic [RISCV_ARCH-1:0] i_div_res;
  logic [5:0]            i_div_waddr;
  logic [TAG_W-1:0]      i_div_tag;
  logic                  i_flush;
  logic                  i_wready;
  logic                  o_wena;
  logic [5:0]            o_waddr;
  logic [RISCV_ARCH-1:0] o_wdata;
  logic [TAG_W-1:0]      o_wtag;
  logic                  o_full;
  logic [2:0]            o_count;
  logic                  o_overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [RISCV_ARCH-1:0] exp_q[$];

  arith_wb_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mul_valid(i_mul_valid), .i_mul_res(i_mul_res), .i_mul_waddr(i_mul_waddr), .i_mul_tag(i_mul_tag),
    .i_div_valid(i_div_valid), .i_div_res(i_div_res), .i_div_waddr(i_div_waddr), .i_div_tag(i_div_tag),
    .i_flush(i_flush), .i_wready(i_wready),
    .o_wena(o_wena), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wtag(o_wtag),
    .o_full(o_full), .o_count(o_count), .o_overflow(o_overflow)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_mul(input logic v, input logic [63:0] res, input logic [5:0] wa, input logic [3:0] tg);
    i_mul_valid = v; i_mul_res = res; i_mul_waddr = wa; i_mul_tag = tg;
  endtask

  task automatic drive_div(input logic v, input logic [63:0] res, input logic [5:0] wa, input logic [3:0] tg);
    i_div_valid = v; i_div_res = res; i_div_waddr = wa; i_div_tag = tg;
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_wready = 1'b0;
    drive_mul(1'b1, 64'h99, 6'd1, 4'd1);
    drive_div(1'b0, 64'h0, 6'd0, 4'd0);

    // Reset held two cycles with a mul strobe present
    tick(); tick();
    check("rst_wena", 64'(o_wena), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    i_rst = 1'b0; drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    tick();
    check("rst_rel_wena", 64'(o_wena), 64'd0);
    check("rst_rel_count", 64'(o_count), 64'd0);
    check("rst_rel_ovf", 64'(o_overflow), 64'd0);
    check("rst_rel_full", 64'(o_full), 64'd0);

    // Ordering: mul before div in the same cycle
    i_wready = 1'b1;
    drive_mul(1'b1, 64'h11, 6'd5, 4'd1);
    drive_div(1'b1, 64'h22, 6'd6, 4'd2);
    tick();
    drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    drive_div(1'b0, 64'h0, 6'd0, 4'd0);
    check("ord_wena0", 64'(o_wena), 64'd1);
    check("ord_data0", o_wdata, 64'h11);
    check("ord_waddr0", 64'(o_waddr), 64'd5);
    check("ord_tag0", 64'(o_wtag), 64'd1);
    check("ord_count0", 64'(o_count), 64'd2);
    tick();
    check("ord_data1", o_wdata, 64'h22);
    check("ord_waddr1", 64'(o_waddr), 64'd6);
    check("ord_tag1", 64'(o_wtag), 64'd2);
    check("ord_count1", 64'(o_count), 64'd1);
    tick();
    check("ord_empty", 64'(o_wena), 64'd0);

    // Backpressure and full threshold
    i_wready = 1'b0;
    drive_mul(1'b1, 64'hA0, 6'd10, 4'd3); tick();
    check("bp_count1", 64'(o_count), 64'd1);
    check("bp_full1", 64'(o_full), 64'd0);
    drive_mul(1'b1, 64'hA1, 6'd11, 4'd3); tick();
    check("bp_full2", 64'(o_full), 64'd0);
    drive_mul(1'b1, 64'hA2, 6'd12, 4'd3); tick();
    check("bp_count3", 64'(o_count), 64'd3);
    check("bp_full3", 64'(o_full), 64'd1);
    check("bp_hold", o_wdata, 64'hA0);
    drive_mul(1'b1, 64'hA3, 6'd13, 4'd3); tick();
    check("bp_count4", 64'(o_count), 64'd4);
    check("bp_ovf4", 64'(o_overflow), 64'd0);

    // Push plus pop at full: no overflow
    i_wready = 1'b1;
    drive_mul(1'b1, 64'hA4, 6'd14, 4'd3); tick();
    check("fpp_count", 64'(o_count), 64'd4);
    check("fpp_ovf", 64'(o_overflow), 64'd0);
    check("fpp_head", o_wdata, 64'hA1);

    // Push at full without pop: dropped, sticky overflow
    i_wready = 1'b0;
    drive_mul(1'b1, 64'hA5, 6'd15, 4'd3); tick();
    drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    check("ovf_count", 64'(o_count), 64'd4);
    check("ovf_flag", 64'(o_overflow), 64'd1);
    check("ovf_head", o_wdata, 64'hA1);

    // Drain: A5 must not appear
    exp_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
    i_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_wena", 64'(o_wena), 64'd1);
      check("drain_data", o_wdata, exp_q.pop_front());
      tick();
    end
    check("drain_empty", 64'(o_wena), 64'd0);
    check("drain_ovf_sticky", 64'(o_overflow), 64'd1);

    // Reset mid-operation
    i_wready = 1'b0;
    drive_mul(1'b1, 64'h55, 6'd2, 4'd4); tick();
    drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    check("mrst_pre_count", 64'(o_count), 64'd1);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    check("mrst_count", 64'(o_count), 64'd0);
    check("mrst_wena", 64'(o_wena), 64'd0);
    check("mrst_ovf", 64'(o_overflow), 64'd0);

    // Flush discards entries and a same-cycle div push
    drive_mul(1'b1, 64'h61, 6'd3, 4'd5);
    drive_div(1'b1, 64'h62, 6'd4, 4'd6);
    tick();
    check("fl_pre_count", 64'(o_count), 64'd2);
    drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    drive_div(1'b1, 64'h77, 6'd7, 4'd7);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    drive_div(1'b0, 64'h0, 6'd0, 4'd0);
    check("fl_count", 64'(o_count), 64'd0);
    check("fl_wena", 64'(o_wena), 64'd0);
    tick();
    check("fl_still_empty", 64'(o_count), 64'd0);
    drive_mul(1'b1, 64'h88, 6'd8, 4'd8); tick();
    drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    check("fl_after_count", 64'(o_count), 64'd1);
    check("fl_after_data", o_wdata, 64'h88);
    i_wready = 1'b1; tick();
    check("fl_after_empty", 64'(o_wena), 64'd0);

    // Wrap: ten pushes with concurrent pops
    for (int i = 0; i < 10; i++) begin
      drive_mul(1'b1, 64'h100 + 64'(i), 6'(i), 4'(i));
      exp_q.push_back(64'h100 + 64'(i));
      tick();
      check("wrap_wena", 64'(o_wena), 64'd1);
      check("wrap_count", 64'(o_count), 64'd1);
      check("wrap_data", o_wdata, exp_q.pop_front());
    end
    drive_mul(1'b0, 64'h0, 6'd0, 4'd0);
    tick();
    check("wrap_empty", 64'(o_wena), 64'd0);
    check("wrap_ovf", 64'(o_overflow), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arith_wb_buf.md
ARITH_WB_BUF -- requirements
Module: arith_wb_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries; power of two, minimum 2.
REQ-002 SHALL have parameter TAG_W, default 4, writeback tag width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_mul_valid  in  1  multiplier result strobe, one cycle
- i_mul_res  in  RISCV_ARCH  multiplier result
- i_mul_waddr  in  6  destination register
- i_mul_tag  in  TAG_W  destination tag
- i_div_valid  in  1  divider result strobe, one cycle
- i_div_res  in  RISCV_ARCH  divider result
- i_div_waddr  in  6  destination register
- i_div_tag  in  TAG_W  destination tag
- i_flush  in  1  discard all entries
- i_wready  in  1  writeback port grant
- o_wena  out  1  head entry valid
- o_waddr  out  6  head destination register
- o_wdata  out  RISCV_ARCH  head result
- o_wtag  out  TAG_W  head tag
- o_full  out  1  at most one free slot left; issue stage stalls mul/div
- o_count  out  $clog2(DEPTH)+1  occupied entries
- o_overflow  out  1  sticky: a push was dropped for lack of space

Function
REQ-005 SHALL hold entries in a circular buffer with write pointer, read pointer and count registers; pointers wrap modulo DEPTH.
REQ-006 SHALL accept pushes unconditionally; the producers have no ready input.
REQ-007 SHALL enqueue the mul entry before the div entry when both valid in one cycle (two pushes per cycle).
REQ-008 SHALL pop the head when o_wena=1 and i_wready=1.
REQ-009 SHALL present a pushed entry on the outputs no earlier than the next cycle (registered, no bypass); push at cycle N gives o_wena=1 at N+1 when the buffer was empty.
REQ-010 SHALL allow push and pop in the same cycle, including at full; count = count + pushes - pop.
REQ-011 SHALL drive o_full=1 when count >= DEPTH-1, combinationally from the count register.
REQ-012 SHALL drop a push that finds no free slot after accounting for the same-cycle pop and the earlier mul push; it sets o_overflow=1 until reset.
REQ-013 SHALL, on i_flush=1, set pointers and count to 0 next cycle and ignore any same-cycle push and pop.
REQ-014 SHALL drive o_waddr/o_wdata/o_wtag from the head slot at all times; they are only meaningful while o_wena=1.
REQ-015 SHALL drive o_wena=1 exactly when count != 0.
REQ-016 SHALL keep a held head stable while i_wready=0.

Reset
REQ-017 SHALL, when i_rst=1 at a clock edge, clear wptr, rptr, count and overflow to 0; o_wena=0, o_full=0, o_count=0, o_overflow=0.
REQ-018 SHALL give reset priority over flush, push and pop; reset mid-operation discards all entries.
REQ-019 SHALL not reset the data storage array.

Structure
REQ-020 SHALL place the entry struct (waddr, tag, data) and the register struct (wptr, rptr, count, overflow) in arith_wb_buf_pkg, importing river_cfg_pkg for RISCV_ARCH.
REQ-021 SHALL be one module with no sub-modules; combinational next-state logic in one block and a single clocked register update.

Verification
REQ-022 Reset: assert i_rst for 2 cycles with i_mul_valid=1 -> o_wena=0, o_count=0, o_overflow=0 after release.
REQ-023 Ordering: mul 0x11/waddr 5 and div 0x22/waddr 6 in the same cycle, i_wready=1 -> o_wdata 0x11 at N+1, 0x22 at N+2, then o_wena=0.
REQ-024 Backpressure and full: 3 mul pushes, i_wready=0 -> o_count=3, o_full=1; with DEPTH=4, a 4th push makes o_count=4 and a 5th push sets o_overflow=1 with o_count unchanged.
REQ-025 Wrap: 10 pushes with concurrent pops at DEPTH=4 -> all 10 values in order, o_overflow=0.
REQ-026 Flush: o_count=2, i_flush=1 and i_div_valid=1 in the same cycle -> next cycle o_count=0, o_wena=0, div value never appears.
REQ-027 Full push+pop: count=4, i_wready=1, one mul push -> o_count stays 4, no overflow.
